controle_lotacao: RTL and testbench

//  Parametrised passenger-capacity controller for the elevator car. Counts

---
 rtl/pacote_elevador.sv | 16 +
 rtl/gerador_pisca.sv | 44 ++++
 rtl/controle_lotacao.sv | 144 ++++++++++++++
 tb/tb_controle_lotacao.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pacote_elevador.sv
// Definitions shared by the car-status blocks: load-state encoding and LED colours.
// LED vector bit order is {R, G, B}.
package pacote_elevador;

  typedef enum logic [1:0] {
    NORMAL   = 2'd0,
    ALERTA   = 2'd1,
    EXCEDIDO = 2'd2
  } estado_t;

  localparam logic [2:0] COR_VERDE    = 3'b010;
  localparam logic [2:0] COR_AMARELA  = 3'b110;
  localparam logic [2:0] COR_VERMELHA = 3'b100;
  localparam logic [2:0] COR_APAGADA  = 3'b000;

endpackage

// File: rtl/gerador_pisca.sv
// Blink phase generator: while habilita is high, fase toggles every PISCA_CICLOS
// cycles; dropping habilita clears the count so the next enable starts at phase 0.
module gerador_pisca #(
  parameter int PISCA_CICLOS = 25_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic habilita,
  output logic fase
);

  localparam int CW = (PISCA_CICLOS > 1) ? $clog2(PISCA_CICLOS) : 1;
  localparam logic [CW-1:0] CONT_FIM = CW'(PISCA_CICLOS - 1);

  logic [CW-1:0] cont_q, cont_d;
  logic          fase_q, fase_d;

  always_comb begin
    cont_d = cont_q;
    fase_d = fase_q;
    if (!habilita) begin
      cont_d = '0;
      fase_d = 1'b0;
    end else if (cont_q == CONT_FIM) begin
      cont_d = '0;
      fase_d = ~fase_q;
    end else begin
      cont_d = cont_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cont_q <= '0;
      fase_q <= 1'b0;
    end else begin
      cont_q <= cont_d;
      fase_q <= fase_d;
    end
  end

  assign fase = fase_q;

endmodule

// File: rtl/controle_lotacao.sv
// Elevator car capacity controller: counts entries/exits from door sensors,
// classifies the load with release hysteresis and drives the status LED.
module controle_lotacao
  import pacote_elevador::*;
#(
  parameter int LARGURA       = 4,
  parameter int CAPACIDADE    = 8,
  parameter int LIMITE_ALERTA = 6,
  parameter int LIBERA_CICLOS = 16,
  parameter int PISCA_CICLOS  = 25_000_000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               entrada,
  input  logic               saida,
  input  logic               zerar,
  output logic [LARGURA-1:0] ocupacao,
  output logic               excedido,
  output logic               bloqueio_partida,
  output logic               erro_sensor,
  output logic [2:0]         led_rgb,
  output estado_t            estado_dbg
);

  localparam logic [LARGURA-1:0] OCUP_MAX  = '1;
  localparam logic [LARGURA-1:0] CAP_L     = LARGURA'(CAPACIDADE);
  localparam logic [LARGURA-1:0] ALERTA_L  = LARGURA'(LIMITE_ALERTA);
  localparam int                 LW        = (LIBERA_CICLOS > 1) ? $clog2(LIBERA_CICLOS) : 1;
  localparam logic [LW-1:0]      LIBERA_FIM = LW'(LIBERA_CICLOS - 1);

  logic               entrada_q, saida_q;
  logic               inc, dec;
  logic [LARGURA-1:0] ocupacao_q, ocupacao_d;
  logic               erro_q, erro_d;
  estado_t            estado_q, estado_d;
  logic [LW-1:0]      libera_q, libera_d;
  logic               excedido_q, excedido_d;
  logic [2:0]         led_q, led_d;
  logic               pisca_habilita, pisca_fase;

  assign inc = entrada & ~entrada_q;
  assign dec = saida & ~saida_q;

  // Simultaneous entry and exit cancel; saturating ends flag a sensor fault.
  always_comb begin
    ocupacao_d = ocupacao_q;
    erro_d     = erro_q;
    if (zerar) begin
      ocupacao_d = '0;
      erro_d     = 1'b0;
    end else if (inc && !dec) begin
      if (ocupacao_q == OCUP_MAX) erro_d = 1'b1;
      else                        ocupacao_d = ocupacao_q + 1'b1;
    end else if (dec && !inc) begin
      if (ocupacao_q == '0) erro_d = 1'b1;
      else                  ocupacao_d = ocupacao_q - 1'b1;
    end
  end

  // Load FSM works on the registered count, so it trails the counter by one cycle.
  always_comb begin
    estado_d = estado_q;
    libera_d = '0;
    if (zerar) begin
      estado_d = NORMAL;
    end else begin
      case (estado_q)
        NORMAL: begin
          if (ocupacao_q > CAP_L)          estado_d = EXCEDIDO;
          else if (ocupacao_q >= ALERTA_L) estado_d = ALERTA;
        end
        ALERTA: begin
          if (ocupacao_q > CAP_L)         estado_d = EXCEDIDO;
          else if (ocupacao_q < ALERTA_L) estado_d = NORMAL;
        end
        EXCEDIDO: begin
          // Leave only after LIBERA_CICLOS uninterrupted cycles within capacity.
          if (ocupacao_q > CAP_L) begin
            libera_d = '0;
          end else if (libera_q == LIBERA_FIM) begin
            estado_d = (ocupacao_q >= ALERTA_L) ? ALERTA : NORMAL;
          end else begin
            libera_d = libera_q + 1'b1;
          end
        end
        default: estado_d = NORMAL;
      endcase
    end
  end

  // Blink timer runs from the cycle the FSM decides to enter EXCEDIDO, so the
  // first registered red phase lasts exactly PISCA_CICLOS cycles.
  assign pisca_habilita = (estado_d == EXCEDIDO);

  gerador_pisca #(
    .PISCA_CICLOS (PISCA_CICLOS)
  ) u_pisca (
    .clk      (clk),
    .rst_n    (rst_n),
    .habilita (pisca_habilita),
    .fase     (pisca_fase)
  );

  always_comb begin
    excedido_d = (estado_d == EXCEDIDO);
    led_d      = COR_VERDE;
    case (estado_d)
      NORMAL:   led_d = COR_VERDE;
      ALERTA:   led_d = COR_AMARELA;
      EXCEDIDO: led_d = pisca_fase ? COR_APAGADA : COR_VERMELHA;
      default:  led_d = COR_VERDE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entrada_q  <= 1'b0;
      saida_q    <= 1'b0;
      ocupacao_q <= '0;
      erro_q     <= 1'b0;
      estado_q   <= NORMAL;
      libera_q   <= '0;
      excedido_q <= 1'b0;
      led_q      <= COR_VERDE;
    end else begin
      entrada_q  <= entrada;
      saida_q    <= saida;
      ocupacao_q <= ocupacao_d;
      erro_q     <= erro_d;
      estado_q   <= estado_d;
      libera_q   <= libera_d;
      excedido_q <= excedido_d;
      led_q      <= led_d;
    end
  end

  assign ocupacao         = ocupacao_q;
  assign excedido         = excedido_q;
  assign bloqueio_partida = excedido_q;
  assign erro_sensor      = erro_q;
  assign led_rgb          = led_q;
  assign estado_dbg       = estado_q;

endmodule

// File: tb/tb_controle_lotacao.sv
// Directed bench for controle_lotacao with a short blink period (4 cycles).
module tb_controle_lotacao;
  import pacote_elevador::*;

  logic       clk;
  logic       rst_n;
  logic       entrada;
  logic       saida;
  logic       zerar;
  logic [3:0] ocupacao;
  logic       excedido;
  logic       bloqueio_partida;
  logic       erro_sensor;
  logic [2:0] led_rgb;
  estado_t    estado_dbg;

  int checks = 0;
  int errors = 0;

  controle_lotacao #(
    .LARGURA       (4),
    .CAPACIDADE    (8),
    .LIMITE_ALERTA (6),
    .LIBERA_CICLOS (16),
    .PISCA_CICLOS  (4)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .entrada          (entrada),
    .saida            (saida),
    .zerar            (zerar),
    .ocupacao         (ocupacao),
    .excedido         (excedido),
    .bloqueio_partida (bloqueio_partida),
    .erro_sensor      (erro_sensor),
    .led_rgb          (led_rgb),
    .estado_dbg       (estado_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks: inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse_in();
    entrada = 1'b1;
    tick();
    entrada = 1'b0;
    tick();
  endtask

  task automatic pulse_out();
    saida = 1'b1;
    tick();
    saida = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; entrada = 1'b0; saida = 1'b0; zerar = 1'b0;
    tick(); tick();
    checks++;
    if (ocupacao !== 4'd0 || led_rgb !== 3'b010 || excedido !== 1'b0 || erro_sensor !== 1'b0) begin
      errors++;
      $display("FAIL reset_init: ocup=%0d led=%b exc=%b err=%b, want 0 010 0 0", ocupacao, led_rgb, excedido, erro_sensor);
    end
    rst_n = 1'b1;
    tick();
    repeat (5) pulse_in();
    checks++;
    if (ocupacao !== 4'd5) begin
      errors++;
      $display("FAIL reset_precount: ocup=%0d want 5", ocupacao);
    end
    // Assert reset between clock edges: outputs must clear without a clock.
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (ocupacao !== 4'd0 || led_rgb !== 3'b010) begin
      errors++;
      $display("FAIL reset_async: ocup=%0d led=%b, want 0 010", ocupacao, led_rgb);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_alerta();
    repeat (6) pulse_in();
    checks++;
    if (ocupacao !== 4'd6 || estado_dbg !== ALERTA || led_rgb !== 3'b110 || excedido !== 1'b0) begin
      errors++;
      $display("FAIL alerta_6: ocup=%0d st=%0d led=%b exc=%b, want 6 1 110 0", ocupacao, estado_dbg, led_rgb, excedido);
    end
  endtask

  task automatic test_excedido_blink();
    logic [2:0] exp_led;
    pulse_in();
    pulse_in();
    checks++;
    if (ocupacao !== 4'd8 || estado_dbg !== ALERTA || excedido !== 1'b0) begin
      errors++;
      $display("FAIL at_capacity: ocup=%0d st=%0d exc=%b, want 8 1 0", ocupacao, estado_dbg, excedido);
    end
    entrada = 1'b1;
    tick();
    checks++;
    if (ocupacao !== 4'd9 || excedido !== 1'b0) begin
      errors++;
      $display("FAIL exceed_count_edge: ocup=%0d exc=%b, want 9 0", ocupacao, excedido);
    end
    entrada = 1'b0;
    tick();
    checks++;
    if (excedido !== 1'b1 || bloqueio_partida !== 1'b1 || estado_dbg !== EXCEDIDO) begin
      errors++;
      $display("FAIL exceed_flag: exc=%b blq=%b st=%0d, want 1 1 2", excedido, bloqueio_partida, estado_dbg);
    end
    for (int k = 0; k < 12; k++) begin
      if (k != 0) tick();
      exp_led = (((k / 4) % 2) == 0) ? 3'b100 : 3'b000;
      checks++;
      if (led_rgb !== exp_led) begin
        errors++;
        $display("FAIL blink_k%0d: led=%b want %b", k, led_rgb, exp_led);
      end
    end
  endtask

  task automatic test_hysteresis();
    int n;
    pulse_out();
    checks++;
    if (ocupacao !== 4'd8 || excedido !== 1'b1) begin
      errors++;
      $display("FAIL hold_start: ocup=%0d exc=%b, want 8 1", ocupacao, excedido);
    end
    n = 0;
    while (excedido === 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (n != 15 || estado_dbg !== ALERTA || led_rgb !== 3'b110) begin
      errors++;
      $display("FAIL hold_release: cycles=%0d st=%0d led=%b, want 15 1 110", n, estado_dbg, led_rgb);
    end
    pulse_in();
    checks++;
    if (excedido !== 1'b1 || ocupacao !== 4'd9) begin
      errors++;
      $display("FAIL reexceed: exc=%b ocup=%0d, want 1 9", excedido, ocupacao);
    end
    // Leave, wait part of the hold, then re-exceed: release count must restart.
    pulse_out();
    repeat (9) tick();
    pulse_in();
    checks++;
    if (excedido !== 1'b1 || ocupacao !== 4'd9) begin
      errors++;
      $display("FAIL restart_stay: exc=%b ocup=%0d, want 1 9", excedido, ocupacao);
    end
    pulse_out();
    n = 0;
    while (excedido === 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (n != 15 || estado_dbg !== ALERTA) begin
      errors++;
      $display("FAIL restart_release: cycles=%0d st=%0d, want 15 1", n, estado_dbg);
    end
  endtask

  task automatic test_sensor_limits();
    zerar = 1'b1;
    tick();
    zerar = 1'b0;
    checks++;
    if (ocupacao !== 4'd0 || estado_dbg !== NORMAL || led_rgb !== 3'b010 || erro_sensor !== 1'b0) begin
      errors++;
      $display("FAIL zerar_alerta: ocup=%0d st=%0d led=%b err=%b, want 0 0 010 0", ocupacao, estado_dbg, led_rgb, erro_sensor);
    end
    tick();
    pulse_out();
    checks++;
    if (ocupacao !== 4'd0 || erro_sensor !== 1'b1) begin
      errors++;
      $display("FAIL underflow: ocup=%0d err=%b, want 0 1", ocupacao, erro_sensor);
    end
    pulse_in();
    pulse_in();
    entrada = 1'b1; saida = 1'b1;
    tick();
    entrada = 1'b0; saida = 1'b0;
    tick();
    checks++;
    if (ocupacao !== 4'd2 || erro_sensor !== 1'b1) begin
      errors++;
      $display("FAIL in_out_same_cycle: ocup=%0d err=%b, want 2 1", ocupacao, erro_sensor);
    end
    zerar = 1'b1; entrada = 1'b1;
    tick();
    zerar = 1'b0; entrada = 1'b0;
    tick();
    checks++;
    if (ocupacao !== 4'd0 || erro_sensor !== 1'b0 || estado_dbg !== NORMAL) begin
      errors++;
      $display("FAIL zerar_priority: ocup=%0d err=%b st=%0d, want 0 0 0", ocupacao, erro_sensor, estado_dbg);
    end
    repeat (15) pulse_in();
    checks++;
    if (ocupacao !== 4'd15 || erro_sensor !== 1'b0 || excedido !== 1'b1) begin
      errors++;
      $display("FAIL count_max: ocup=%0d err=%b exc=%b, want 15 0 1", ocupacao, erro_sensor, excedido);
    end
    pulse_in();
    checks++;
    if (ocupacao !== 4'd15 || erro_sensor !== 1'b1) begin
      errors++;
      $display("FAIL overflow: ocup=%0d err=%b, want 15 1", ocupacao, erro_sensor);
    end
    zerar = 1'b1;
    tick();
    zerar = 1'b0;
    checks++;
    if (ocupacao !== 4'd0 || excedido !== 1'b0 || bloqueio_partida !== 1'b0 ||
        led_rgb !== 3'b010 || erro_sensor !== 1'b0 || estado_dbg !== NORMAL) begin
      errors++;
      $display("FAIL zerar_excedido: ocup=%0d exc=%b blq=%b led=%b err=%b st=%0d, want 0 0 0 010 0 0",
               ocupacao, excedido, bloqueio_partida, led_rgb, erro_sensor, estado_dbg);
    end
    tick();
  endtask

  task automatic test_held_level();
    entrada = 1'b1;
    repeat (20) tick();
    checks++;
    if (ocupacao !== 4'd1 || erro_sensor !== 1'b0) begin
      errors++;
      $display("FAIL held_entrada: ocup=%0d err=%b, want 1 0", ocupacao, erro_sensor);
    end
    entrada = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_alerta();
    test_excedido_blink();
    test_hysteresis();
    test_sensor_limits();
    test_held_level();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
